// File: rtl/spi_motor_cmd_sched_if.sv
// rtl/spi_motor_cmd_sched_if.sv - SPI word and motor channel signals of the command sequencer
interface spi_motor_cmd_sched_if #(
  parameter int NCH = 4
);
  logic           ssel_n;
  logic           word_valid;
  logic [15:0]    word_data;
  logic [15:0]    reply_word;
  logic [NCH-1:0] cmd_valid;
  logic [15:0]    cmd_period;
  logic [15:0]    cmd_steps;
  logic [NCH-1:0] cmd_ready;
  logic [NCH-1:0] ch_busy;
  logic [7:0]     err_count;

  modport master (
    output ssel_n, word_valid, word_data, cmd_ready, ch_busy,
    input  reply_word, cmd_valid, cmd_period, cmd_steps, err_count
  );

  modport slave (
    input  ssel_n, word_valid, word_data, cmd_ready, ch_busy,
    output reply_word, cmd_valid, cmd_period, cmd_steps, err_count
  );
endinterface

// File: rtl/spi_motor_cmd_sched.sv
// rtl/spi_motor_cmd_sched.sv - parses framed SPI words into motor commands and dispatches them
module spi_motor_cmd_sched #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 1000
) (
  input logic                  clk,
  input logic                  rst_n,
  spi_motor_cmd_sched_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_P1  = 3'd1;
  localparam logic [2:0] S_GET_P2  = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  localparam logic [3:0] OP_MOVE   = 4'h1;
  localparam logic [3:0] OP_STOP   = 4'h2;
  localparam logic [3:0] OP_STATUS = 4'h3;

  localparam int         TW    = $clog2(TIMEOUT + 1);
  localparam logic [4:0] NCH_L = 5'(NCH);

  logic [2:0]    state, word_state, next_state;
  logic [2:0]    ssel_sync;
  logic          frame_end, handshake, timed_out, in_payload;
  logic          hdr_ok, word_err, frame_err, any_err;
  logic [3:0]    op, hdr_ch, ch, issue_ch;
  logic [7:0]    seq;
  logic [TW-1:0] timer;

  assign op         = bus.word_data[15:12];
  assign hdr_ch     = bus.word_data[11:8];
  assign hdr_ok     = ((op == OP_MOVE) || (op == OP_STOP) || (op == OP_STATUS)) &&
                      ({1'b0, hdr_ch} < NCH_L);
  assign frame_end  = ssel_sync[1] & ~ssel_sync[2];
  assign handshake  = |(bus.cmd_valid & bus.cmd_ready);
  assign in_payload = (state == S_GET_P1) || (state == S_GET_P2);
  assign timed_out  = in_payload && !bus.word_valid && (timer == TW'(TIMEOUT - 1));
  assign issue_ch   = (state == S_IDLE) ? hdr_ch : ch;
  assign any_err    = word_err | frame_err | timed_out;

  // The word is consumed first; frame end then acts on the state the word produced.
  always_comb begin
    word_state = state;
    word_err   = 1'b0;
    if (bus.word_valid) begin
      case (state)
        S_IDLE: begin
          if (!hdr_ok) begin
            word_state = S_DISCARD;
            word_err   = 1'b1;
          end else if (op == OP_MOVE) begin
            word_state = S_GET_P1;
          end else if (op == OP_STOP) begin
            word_state = S_ISSUE;
          end
        end
        S_GET_P1: word_state = S_GET_P2;
        S_GET_P2: word_state = S_ISSUE;
        S_ISSUE:  word_err   = 1'b1;
        default:  ;
      endcase
    end
    if ((state == S_ISSUE) && handshake) begin
      word_state = S_IDLE;
    end

    next_state = word_state;
    frame_err  = 1'b0;
    if (frame_end) begin
      case (word_state)
        S_GET_P1, S_GET_P2: begin
          next_state = S_IDLE;
          frame_err  = 1'b1;
        end
        S_DISCARD: next_state = S_IDLE;
        default:   ;
      endcase
    end
    if (timed_out) begin
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ssel_sync      <= 3'b111;
      ch             <= 4'd0;
      seq            <= 8'd0;
      timer          <= '0;
      bus.cmd_valid  <= '0;
      bus.cmd_period <= 16'd0;
      bus.cmd_steps  <= 16'd0;
      bus.reply_word <= 16'd0;
      bus.err_count  <= 8'd0;
    end else begin
      ssel_sync <= {ssel_sync[1:0], bus.ssel_n};
      state     <= next_state;

      if (any_err && (bus.err_count != 8'hFF)) begin
        bus.err_count <= bus.err_count + 8'd1;
      end

      if (bus.word_valid && (state == S_IDLE)) begin
        seq <= bus.word_data[7:0];
        ch  <= hdr_ch;
        if (hdr_ok && (op == OP_STOP)) begin
          bus.cmd_period <= 16'd0;
          bus.cmd_steps  <= 16'd0;
        end
      end
      if (bus.word_valid && (state == S_GET_P1)) begin
        bus.cmd_period <= bus.word_data;
      end
      if (bus.word_valid && (state == S_GET_P2)) begin
        bus.cmd_steps <= bus.word_data;
      end

      // Held at zero outside the payload states, so entry to GET_P1 starts a fresh count.
      if (bus.word_valid || !in_payload) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if ((next_state == S_ISSUE) && (state != S_ISSUE)) begin
        bus.cmd_valid <= NCH'(1) << issue_ch;
      end else if ((state == S_ISSUE) && handshake) begin
        bus.cmd_valid <= '0;
      end

      if (frame_end) begin
        bus.reply_word <= {seq, bus.err_count[3:0], 4'(bus.ch_busy)};
      end
    end
  end
endmodule

// File: tb/tb_spi_motor_cmd_sched.sv
// tb/tb_spi_motor_cmd_sched.sv - table, directed and randomized checks of spi_motor_cmd_sched
module tb_spi_motor_cmd_sched;
  localparam int NCH     = 4;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_motor_cmd_sched_if #(.NCH(NCH)) bus ();

  spi_motor_cmd_sched #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  vec;
    logic [15:0] period;
    logic [15:0] steps;
  } disp_t;

  typedef struct {
    logic [15:0] w0, w1, w2;
    int          nw;
    bit          disp;
    logic [3:0]  vec;
    logic [15:0] per, stp;
    int          err_inc;
    bit          chk_reply;
    logic [15:0] reply;
  } vec_t;

  disp_t       obs_q[$];
  disp_t       exp_q[$];
  logic [15:0] gw[$];
  bit          glg[$];
  vec_t        tbl[8];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_err = 0;
  logic [7:0]  m_seq = 8'h00;
  logic [3:0]  m_ch = 4'h0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (!$onehot0(bus.cmd_valid)) begin
        n_fail++;
        $display("FAIL cmd_valid_onehot0: got %b required one-hot or zero", bus.cmd_valid);
      end
      if ((bus.cmd_valid & bus.cmd_ready) != '0)
        obs_q.push_back('{bus.cmd_valid & bus.cmd_ready, bus.cmd_period, bus.cmd_steps});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic send_word(logic [15:0] w, int gap);
    bus.word_data  = w;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    idle(gap);
  endtask

  task automatic frame_start();
    bus.ssel_n = 1'b0;
    idle(3);
  endtask

  task automatic frame_stop();
    bus.ssel_n = 1'b1;
    idle(5);
  endtask

  task automatic bump();
    if (m_err < 255) m_err++;
  endtask

  task automatic cmp_disp(string name);
    chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({name, "_vec"},    32'(obs_q[i].vec),    32'(exp_q[i].vec));
      chk({name, "_period"}, 32'(obs_q[i].period), 32'(exp_q[i].period));
      chk({name, "_steps"},  32'(obs_q[i].steps),  32'(exp_q[i].steps));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Frame-level reference: walks the word list with the command grammar, no cycle timing.
  task automatic model_frame(output bit aborted);
    int          mode;
    logic [3:0]  op, c;
    logic [15:0] w, p;
    mode = 0;
    p    = 16'h0;
    for (int i = 0; i < gw.size(); i++) begin
      w = gw[i];
      if (glg[i] && (mode == 1 || mode == 2)) begin
        bump();
        mode = 0;
      end
      case (mode)
        0: begin
          m_seq = w[7:0];
          op    = w[15:12];
          c     = w[11:8];
          if (!(op inside {4'h1, 4'h2, 4'h3}) || int'(c) >= NCH) begin
            bump();
            mode = 3;
          end else if (op == 4'h1) begin
            m_ch = c;
            mode = 1;
          end else if (op == 4'h2) begin
            exp_q.push_back('{4'(1 << c), 16'h0, 16'h0});
          end
        end
        1: begin
          p    = w;
          mode = 2;
        end
        2: begin
          exp_q.push_back('{4'(1 << m_ch), p, w});
          mode = 0;
        end
        default: ;
      endcase
    end
    if (glg[gw.size()] && (mode == 1 || mode == 2)) begin
      bump();
      mode = 0;
    end
    aborted = (mode == 1 || mode == 2);
    if (aborted) bump();
  endtask

  initial begin
    int          hi;
    bit          aborted;
    logic [15:0] exp_reply;
    logic [3:0]  busy;
    int          r;
    logic [3:0]  op;

    tbl[0] = '{16'h1105, 16'h0200, 16'h0064, 3, 1, 4'b0010, 16'h0200, 16'h0064, 0, 1, 16'h0505};
    tbl[1] = '{16'h7000, 16'h1234, 16'h5678, 3, 0, 4'b0000, 16'h0000, 16'h0000, 1, 1, 16'h0015};
    tbl[2] = '{16'h1500, 16'h0000, 16'h0000, 1, 0, 4'b0000, 16'h0000, 16'h0000, 1, 1, 16'h0025};
    tbl[3] = '{16'h30AB, 16'h0000, 16'h0000, 1, 0, 4'b0000, 16'h0000, 16'h0000, 0, 1, 16'hAB25};
    tbl[4] = '{16'h2207, 16'h0000, 16'h0000, 1, 1, 4'b0100, 16'h0000, 16'h0000, 0, 1, 16'h0725};
    tbl[5] = '{16'h1310, 16'h0999, 16'h0000, 2, 0, 4'b0000, 16'h0000, 16'h0000, 1, 0, 16'h0000};
    tbl[6] = '{16'h1011, 16'h0000, 16'h0000, 1, 0, 4'b0000, 16'h0000, 16'h0000, 1, 0, 16'h0000};
    tbl[7] = '{16'h13FF, 16'hABCD, 16'h1234, 3, 1, 4'b1000, 16'hABCD, 16'h1234, 0, 1, 16'hFF45};

    rst_n          = 1'b0;
    bus.ssel_n     = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_data  = 16'h0;
    bus.cmd_ready  = 4'hF;
    bus.ch_busy    = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_valid", 32'(bus.cmd_valid), 32'h0);
    chk("reset_period", 32'(bus.cmd_period), 32'h0);
    chk("reset_steps", 32'(bus.cmd_steps), 32'h0);
    chk("reset_reply", 32'(bus.reply_word), 32'h0);
    chk("reset_err", 32'(bus.err_count), 32'h0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      frame_start();
      send_word(tbl[i].w0, 2);
      if (tbl[i].nw > 1) send_word(tbl[i].w1, 2);
      if (tbl[i].nw > 2) send_word(tbl[i].w2, 2);
      frame_stop();
      m_err += tbl[i].err_inc;
      if (tbl[i].disp) exp_q.push_back('{tbl[i].vec, tbl[i].per, tbl[i].stp});
      cmp_disp($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_err", i), 32'(bus.err_count), 32'(m_err));
      if (tbl[i].chk_reply)
        chk($sformatf("tbl%0d_reply", i), 32'(bus.reply_word), 32'(tbl[i].reply));
    end

    // STOP ch2 held off for 20 cycles, with one stray word during the wait.
    frame_start();
    bus.cmd_ready = 4'b1011;
    send_word(16'h2233, 0);
    chk("stop_latency", 32'(bus.cmd_valid), 32'b0100);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_valid == 4'b0100) hi++;
      bus.word_data  = 16'h1105;
      bus.word_valid = (i == 5);
      tick();
    end
    bus.word_valid = 1'b0;
    bus.cmd_ready  = 4'hF;
    if (bus.cmd_valid == 4'b0100) hi++;
    tick();
    chk("stop_hold_cycles", 32'(hi), 32'd21);
    chk("stop_drop", 32'(bus.cmd_valid), 32'h0);
    bump();
    exp_q.push_back('{4'b0100, 16'h0, 16'h0});
    frame_stop();
    cmp_disp("stop_wait");
    chk("stop_wait_err", 32'(bus.err_count), 32'(m_err));

    // Reply stays put while ch_busy moves inside a frame.
    exp_reply = {8'h33, 4'(m_err), 4'b0101};
    chk("reply_before", 32'(bus.reply_word), 32'(exp_reply));
    frame_start();
    bus.ch_busy = 4'b1010;
    idle(4);
    chk("reply_midframe", 32'(bus.reply_word), 32'(exp_reply));
    frame_stop();
    chk("reply_after", 32'(bus.reply_word), 32'({8'h33, 4'(m_err), 4'b1010}));
    bus.ch_busy = 4'b0101;

    // Payload gap beyond TIMEOUT aborts; gaps inside it are accepted.
    frame_start();
    send_word(16'h1102, 2);
    send_word(16'h0500, 0);
    idle(TIMEOUT + 3);
    bump();
    chk("timeout_err", 32'(bus.err_count), 32'(m_err));
    send_word(16'h1103, TIMEOUT - 10);
    send_word(16'h0600, TIMEOUT - 10);
    send_word(16'h0700, 2);
    exp_q.push_back('{4'b0010, 16'h0600, 16'h0700});
    frame_stop();
    cmp_disp("timeout");
    chk("timeout_err2", 32'(bus.err_count), 32'(m_err));

    // Last payload word in the same cycle as frame end still issues.
    frame_start();
    send_word(16'h1201, 2);
    send_word(16'h0111, 2);
    bus.ssel_n = 1'b1;
    tick();
    tick();
    bus.word_data  = 16'h0222;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    idle(4);
    exp_q.push_back('{4'b0100, 16'h0111, 16'h0222});
    cmp_disp("p2_frame_end");
    chk("p2_frame_end_err", 32'(bus.err_count), 32'(m_err));

    // First payload word with frame end aborts.
    frame_start();
    send_word(16'h1302, 2);
    bus.ssel_n = 1'b1;
    tick();
    tick();
    bus.word_data  = 16'h0333;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    idle(4);
    bump();
    cmp_disp("p1_frame_end");
    chk("p1_frame_end_err", 32'(bus.err_count), 32'(m_err));

    for (int f = 0; f < 40; f++) begin
      gw.delete();
      glg.delete();
      r = $urandom_range(1, 4);
      for (int k = 0; k < r; k++) begin
        int sel, np;
        sel = $urandom_range(0, 9);
        op  = (sel < 5) ? 4'h1 : (sel < 7) ? 4'h2 : (sel < 8) ? 4'h3 :
              (sel < 9) ? 4'h0 : 4'($urandom_range(4, 15));
        gw.push_back({op, 4'($urandom_range(0, 4)), 8'($urandom)});
        if (op == 4'h1) begin
          np = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : 2;
          for (int j = 0; j < np; j++) gw.push_back(16'($urandom));
          if (np < 2) break;
        end
      end
      for (int i = 0; i <= gw.size(); i++) glg.push_back($urandom_range(0, 11) == 0);
      busy        = 4'($urandom);
      bus.ch_busy = busy;
      frame_start();
      for (int i = 0; i < gw.size(); i++) begin
        if (glg[i]) idle(TIMEOUT + 3);
        send_word(gw[i], $urandom_range(1, 3));
      end
      if (glg[gw.size()]) idle(TIMEOUT + 3);
      frame_stop();
      model_frame(aborted);
      cmp_disp($sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_err", f), 32'(bus.err_count), 32'(m_err));
      if (!aborted)
        chk($sformatf("rnd%0d_reply", f), 32'(bus.reply_word), 32'({m_seq, 4'(m_err), busy}));
    end

    // Reset while waiting for the step count.
    bus.ch_busy = 4'b0101;
    frame_start();
    send_word(16'h1101, 2);
    send_word(16'h0222, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_p2_period", 32'(bus.cmd_period), 32'h0);
    chk("rst_p2_err", 32'(bus.err_count), 32'h0);
    chk("rst_p2_reply", 32'(bus.reply_word), 32'h0);
    rst_n = 1'b1;
    m_err = 0;
    obs_q.delete();
    exp_q.delete();
    tick();

    // Reset while a command waits for its handshake.
    bus.cmd_ready = 4'b0000;
    send_word(16'h2301, 1);
    send_word(16'h1111, 1);
    chk("pre_rst_issue_valid", 32'(bus.cmd_valid), 32'b1000);
    chk("pre_rst_issue_err", 32'(bus.err_count), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(bus.cmd_valid), 32'h0);
    chk("rst_issue_err", 32'(bus.err_count), 32'h0);
    chk("rst_issue_steps", 32'(bus.cmd_steps), 32'h0);
    rst_n = 1'b1;
    tick();
    bus.cmd_ready = 4'hF;
    idle(2);
    chk("post_rst_valid", 32'(bus.cmd_valid), 32'h0);
    frame_stop();
    cmp_disp("post_rst");

    // Error counter saturation using words dropped during ISSUE.
    frame_start();
    bus.cmd_ready = 4'b0000;
    send_word(16'h2000, 0);
    bus.word_data  = 16'h5555;
    bus.word_valid = 1'b1;
    idle(254);
    chk("sat_254", 32'(bus.err_count), 32'hFE);
    idle(46);
    bus.word_valid = 1'b0;
    chk("sat_300", 32'(bus.err_count), 32'hFF);
    bus.cmd_ready = 4'hF;
    idle(2);
    exp_q.push_back('{4'b0001, 16'h0, 16'h0});
    frame_stop();
    cmp_disp("sat");
    chk("sat_final", 32'(bus.err_count), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
